lif_spike_generator: RTL and testbench

- Leaky integrate-and-fire neuron. Consumes the signed 5-bit input current produced by the spike-weighted adder tree and emits a one-cycle output spike.
- This converts current back into spikes, the reverse of the spike-to-current path.
- Integrates once per timestep strobe, applies shift-based leak, fires on threshold, then holds a programmable refractory period.
- Sits between the input current calculator and the next layer's input_spikes bus.

---
 rtl/lif_spike_generator_if.sv | 27 ++
 rtl/lif_spike_generator.sv | 110 +++++++++++
 tb/tb_lif_spike_generator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lif_spike_generator_if.sv
// Bus between the current calculator and the LIF neuron: timestep strobe, current,
// neuron configuration, and the spike/potential/refractory status.
`timescale 1ns/1ps
interface lif_spike_generator_if #(
    parameter int unsigned CURRENT_WIDTH = 5,
    parameter int unsigned POT_WIDTH     = 8,
    parameter int unsigned REFRAC_WIDTH  = 4
);
    logic                     step_en;
    logic [CURRENT_WIDTH-1:0] input_current;
    logic [POT_WIDTH-1:0]     threshold;
    logic [2:0]               decay_shift;
    logic [REFRAC_WIDTH-1:0]  refractory_period;
    logic                     spike_out;
    logic [POT_WIDTH-1:0]     membrane_potential;
    logic                     refractory;

    modport master (
        output step_en, input_current, threshold, decay_shift, refractory_period,
        input  spike_out, membrane_potential, refractory
    );

    modport slave (
        input  step_en, input_current, threshold, decay_shift, refractory_period,
        output spike_out, membrane_potential, refractory
    );
endinterface

// File: rtl/lif_spike_generator.sv
// Leaky integrate-and-fire neuron: integrates signed current per timestep strobe,
// shift leak, fires on threshold, then a refractory hold. LIF_SPIKE_COUNT_EN adds a spike counter.
`timescale 1ns/1ps
module lif_spike_generator #(
    parameter int unsigned CURRENT_WIDTH = 5,
    parameter int unsigned POT_WIDTH     = 8,
    parameter int unsigned REFRAC_WIDTH  = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef LIF_SPIKE_COUNT_EN
    input  logic       count_clr,
    output logic [7:0] spike_count,
`endif
    lif_spike_generator_if.slave bus
);
    // Two guard bits: one for the sign, one for overflow past 2^POT_WIDTH-1
    localparam int unsigned SUM_W = POT_WIDTH + 2;

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [POT_WIDTH-1:0]    pot_q, pot_d;
    logic [REFRAC_WIDTH-1:0] cnt_q, cnt_d;
    logic                    spike_q, spike_d;

    logic [POT_WIDTH-1:0] leak;
    logic [SUM_W-1:0]     cur_ext;
    logic [SUM_W-1:0]     sum;
    logic [POT_WIDTH-1:0] clamped;

    assign cur_ext = {{(SUM_W-CURRENT_WIDTH){bus.input_current[CURRENT_WIDTH-1]}}, bus.input_current};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INTEGRATE;
            pot_q   <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

    // Next-state: integrate/leak/fire, or count down the refractory strobes
    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        leak    = '0;
        sum     = '0;
        clamped = '0;
        if (bus.step_en) begin
            case (state_q)
                INTEGRATE: begin
                    leak = (bus.decay_shift == 3'd0) ? '0 : (pot_q >> bus.decay_shift);
                    sum  = SUM_W'(pot_q) - SUM_W'(leak) + cur_ext;
                    if (sum[SUM_W-1])
                        clamped = '0;
                    else if (|sum[SUM_W-2:POT_WIDTH])
                        clamped = '1;
                    else
                        clamped = sum[POT_WIDTH-1:0];
                    if (clamped >= bus.threshold) begin
                        spike_d = 1'b1;
                        pot_d   = '0;
                        if (bus.refractory_period != '0) begin
                            state_d = REFRACTORY;
                            cnt_d   = bus.refractory_period;
                        end
                    end else begin
                        pot_d = clamped;
                    end
                end
                REFRACTORY: begin
                    pot_d = '0;
                    if (cnt_q == REFRAC_WIDTH'(1)) begin
                        cnt_d   = '0;
                        state_d = INTEGRATE;
                    end else begin
                        cnt_d = cnt_q - REFRAC_WIDTH'(1);
                    end
                end
                default: state_d = INTEGRATE;
            endcase
        end
    end

    assign bus.spike_out          = spike_q;
    assign bus.membrane_potential = pot_q;
    assign bus.refractory         = (state_q == REFRACTORY);

`ifdef LIF_SPIKE_COUNT_EN
    // Saturating fire counter; clear wins over a simultaneous fire
    always_ff @(posedge clk) begin
        if (!rst_n || count_clr)
            spike_count <= 8'd0;
        else if (spike_d && spike_count != 8'hFF)
            spike_count <= spike_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_lif_spike_generator.sv
// Directed self-checking bench for lif_spike_generator (counter checks when LIF_SPIKE_COUNT_EN is defined).
`timescale 1ns/1ps
module tb_lif_spike_generator;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lif_spike_generator_if #(.CURRENT_WIDTH(5), .POT_WIDTH(8), .REFRAC_WIDTH(4)) bus ();

`ifdef LIF_SPIKE_COUNT_EN
    logic       count_clr;
    logic [7:0] spike_count;
`endif

    lif_spike_generator #(.CURRENT_WIDTH(5), .POT_WIDTH(8), .REFRAC_WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef LIF_SPIKE_COUNT_EN
        .count_clr   (count_clr),
        .spike_count (spike_count),
`endif
        .bus         (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One timestep strobe; outputs sampled 1ns after the edge
    task automatic strobe(input int cur);
        @(negedge clk);
        bus.step_en       = 1'b1;
        bus.input_current = 5'(cur);
        @(posedge clk);
        #1;
        bus.step_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n             = 1'b0;
        bus.step_en       = 1'b1;
        bus.input_current = 5'd15;
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.step_en = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int v, input int sp, input int rf);
        check({tag, "_v"},     int'(bus.membrane_potential), v);
        check({tag, "_spike"}, int'(bus.spike_out), sp);
        check({tag, "_refr"},  int'(bus.refractory), rf);
    endtask

    initial begin
        rst_n                 = 1'b1;
        bus.step_en           = 1'b0;
        bus.input_current     = '0;
        bus.threshold         = 8'd0;
        bus.decay_shift       = 3'd0;
        bus.refractory_period = 4'd0;
`ifdef LIF_SPIKE_COUNT_EN
        count_clr = 1'b0;
`endif

        // Reset with a strobe that would otherwise fire
        do_reset();
        chk_out("reset", 0, 0, 0);

        // Integration to threshold
        bus.threshold = 8'd40;
        strobe(10); chk_out("int1", 10, 0, 0);
        strobe(10); chk_out("int2", 20, 0, 0);
        strobe(10); chk_out("int3", 30, 0, 0);
        strobe(10); chk_out("int4_fire", 0, 1, 0);
        idle(1);    chk_out("int_after", 0, 0, 0);

        // Leak: build v=64, then shift-2 leak
        bus.threshold = 8'd255;
        repeat (4) strobe(15);
        strobe(4);  check("leak_pre", int'(bus.membrane_potential), 64);
        bus.decay_shift = 3'd2;
        strobe(0);  chk_out("leak1", 48, 0, 0);
        strobe(0);  chk_out("leak2", 36, 0, 0);

        // Floor clamp
        do_reset();
        bus.decay_shift = 3'd0;
        strobe(3);   check("floor_pre", int'(bus.membrane_potential), 3);
        strobe(-16); chk_out("floor", 0, 0, 0);

        // Idle cycles hold the potential
        strobe(7);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("idle_v", int'(bus.membrane_potential), 7);
        end
        check("idle_spike", int'(bus.spike_out), 0);

        // Refractory hold of three strobes
        do_reset();
        bus.threshold         = 8'd5;
        bus.refractory_period = 4'd3;
        strobe(15); chk_out("ref_s1", 0, 1, 1);
        strobe(15); chk_out("ref_s2", 0, 0, 1);
        strobe(15); chk_out("ref_s3", 0, 0, 1);
        strobe(15); chk_out("ref_s4", 0, 0, 0);
        strobe(15); chk_out("ref_s5", 0, 1, 1);
        // Period change mid-refractory is ignored (latched 3 on fire)
        bus.refractory_period = 4'd1;
        strobe(15); chk_out("ref_s6", 0, 0, 1);
        strobe(15); chk_out("ref_s7", 0, 0, 1);
        do_reset(); chk_out("ref_rst", 0, 0, 0);

        // Saturation at 255 fires at threshold 255
        bus.threshold         = 8'd255;
        bus.refractory_period = 4'd0;
        repeat (16) strobe(15);
        strobe(10); chk_out("sat_pre", 250, 0, 0);
        strobe(15); chk_out("sat_fire", 0, 1, 0);

        // Zero threshold fires every strobe even with negative current
        bus.threshold = 8'd0;
        strobe(-16); chk_out("thr0_a", 0, 1, 0);
        strobe(-16); chk_out("thr0_b", 0, 1, 0);
        strobe(-16); chk_out("thr0_c", 0, 1, 0);

`ifdef LIF_SPIKE_COUNT_EN
        do_reset();
        check("cnt_reset", int'(spike_count), 0);
        for (int i = 0; i < 300; i++) strobe(0);
        check("cnt_sat", int'(spike_count), 255);
        count_clr = 1'b1;
        strobe(0);
        count_clr = 1'b0;
        check("cnt_clr_fire", int'(spike_count), 0);
        strobe(0);
        check("cnt_after_clr", int'(spike_count), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
